parallel_fifo: RTL and testbench

PARALLEL_FIFO -- requirements
Module: parallel_fifo

---
 rtl/parallel_fifo.sv | 100 ++++++++++
 tb/tb_parallel_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/parallel_fifo.sv
// parallel_fifo: synchronous FIFO with valid/ready handshakes on both sides.
// A push and a pop can happen in the same cycle, including when the FIFO is full.
// Parameters:
//   WIDTH        data word width (>= 1)
//   DEPTH        number of entries (power of two, >= 2)
//   ALMOST_FULL  occupancy threshold for almost_full (1..DEPTH)
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   data_in      word offered by upstream
//   write_in     upstream valid
//   flush        synchronous discard of all stored words
//   next_ready   downstream accepts the head word this cycle
//   write_ready  FIFO accepts data_in this cycle
//   data_out     head word (zero when empty)
//   write_out    data_out is valid
//   count        current occupancy (0..DEPTH)
//   almost_full  count >= ALMOST_FULL
module parallel_fifo #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ALMOST_FULL = DEPTH - 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       write_in,
   input  logic                       flush,
   input  logic                       next_ready,
   output logic                       write_ready,
   output logic [WIDTH-1:0]           data_out,
   output logic                       write_out,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       almost_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push;
   logic             pop;

   // Handshake terms; write_ready uses only registered state and next_ready.
   always_comb begin
      write_ready = (count_q != CW'(DEPTH)) || next_ready;
      write_out   = (count_q != CW'(0));
      push        = write_in && write_ready;
      pop         = write_out && next_ready;
   end

   // Outputs derived from registered state.
   always_comb begin
      count       = count_q;
      almost_full = (count_q >= CW'(ALMOST_FULL));
      data_out    = write_out ? mem_q[rd_ptr_q] : '0;
   end

   // Next-state for pointers and occupancy; flush overrides push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; a flushed push is dropped.
   always_ff @(posedge clock) begin
      if (push && !flush) mem_q[wr_ptr_q] <= data_in;
   end

endmodule

// File: tb/tb_parallel_fifo.sv
module tb_parallel_fifo;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AF    = DEPTH - 1;

   logic             clock = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] data_in;
   logic             write_in;
   logic             flush;
   logic             next_ready;
   logic             write_ready;
   logic [WIDTH-1:0] data_out;
   logic             write_out;
   logic [2:0]       count;
   logic             almost_full;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [WIDTH-1:0] mq [$];

   parallel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
      .clock       (clock),
      .reset       (reset),
      .data_in     (data_in),
      .write_in    (write_in),
      .flush       (flush),
      .next_ready  (next_ready),
      .write_ready (write_ready),
      .data_out    (data_out),
      .write_out   (write_out),
      .count       (count),
      .almost_full (almost_full)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Compare all outputs against the queue model at the negedge, then apply the edge.
   task automatic cycle();
      bit exp_wr, do_push, do_pop;
      @(negedge clock);
      exp_wr  = (mq.size() != DEPTH) || next_ready;
      check("count",       32'(count),       32'(mq.size()));
      check("write_out",   32'(write_out),   32'(mq.size() != 0));
      check("data_out",    32'(data_out),    (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      check("write_ready", 32'(write_ready), 32'(exp_wr));
      check("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      do_push = write_in && exp_wr;
      do_pop  = (mq.size() != 0) && next_ready;
      @(posedge clock);
      if (flush) mq.delete();
      else begin
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(data_in);
      end
      #1;
   endtask

   task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic nr, input logic fl);
      write_in   = w;
      data_in    = d;
      next_ready = nr;
      flush      = fl;
   endtask

   initial begin
      logic [WIDTH-1:0] pat;
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      check("rst_count",   32'(count),       32'h0);
      check("rst_wout",    32'(write_out),   32'h0);
      check("rst_dout",    32'(data_out),    32'h0);
      check("rst_wready",  32'(write_ready), 32'h1);
      check("rst_afull",   32'(almost_full), 32'h0);
      reset = 1'b0;

      // Fill with next_ready low.
      drive(1'b1, 8'h11, 1'b0, 1'b0); cycle();
      drive(1'b1, 8'h22, 1'b0, 1'b0); cycle();
      drive(1'b1, 8'h33, 1'b0, 1'b0); cycle();
      check("af_at_3", 32'(almost_full), 32'h1);
      drive(1'b1, 8'h44, 1'b0, 1'b0); cycle();
      check("full_count",  32'(count),       32'h4);
      check("full_wready", 32'(write_ready), 32'h0);
      check("full_head",   32'(data_out),    32'h11);

      // Push and pop together while full.
      drive(1'b1, 8'h55, 1'b1, 1'b0); cycle();
      check("fullpp_count", 32'(count),    32'h4);
      check("fullpp_head",  32'(data_out), 32'h22);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (5) cycle();
      check("drained", 32'(count), 32'h0);

      // Single word through an empty FIFO.
      check("empty_wout", 32'(write_out), 32'h0);
      drive(1'b1, 8'hA5, 1'b1, 1'b0); cycle();
      check("one_wout", 32'(write_out), 32'h1);
      check("one_dout", 32'(data_out),  32'hA5);
      drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();
      check("one_gone", 32'(data_out), 32'h0);

      // Streaming at count == 1 across pointer wrap.
      pat = 8'h80;
      drive(1'b1, pat, 1'b0, 1'b0); cycle();
      for (int i = 0; i < 3 * DEPTH; i++) begin
         pat = pat + 8'h01;
         drive(1'b1, pat, 1'b1, 1'b0); cycle();
      end
      check("stream_head", 32'(data_out), 32'(pat));
      drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();

      // Flush with a concurrent push.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0); cycle();
      end
      drive(1'b1, 8'h77, 1'b0, 1'b1); cycle();
      check("flush_count", 32'(count),     32'h0);
      check("flush_wout",  32'(write_out), 32'h0);
      check("flush_dout",  32'(data_out),  32'h0);
      drive(1'b0, 8'h00, 1'b0, 1'b0); cycle();

      // Asynchronous reset between edges with two words stored.
      drive(1'b1, 8'h91, 1'b0, 1'b0); cycle();
      drive(1'b1, 8'h92, 1'b0, 1'b0); cycle();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("arst_count",  32'(count),       32'h0);
      check("arst_wout",   32'(write_out),   32'h0);
      check("arst_dout",   32'(data_out),    32'h0);
      check("arst_wready", 32'(write_ready), 32'h1);
      mq.delete();
      @(posedge clock);
      #1 reset = 1'b0;
      drive(1'b1, 8'h3C, 1'b0, 1'b0); cycle();
      check("post_rst_head", 32'(data_out), 32'h3C);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 50),
               1'($urandom_range(0, 31) == 0));
         cycle();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0); cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
